// File: rtl/uart_tx.sv
// uart_tx: serial byte transmitter, LSB first, start/8 data/[parity]/stop, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd, else even).
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_out,
    output logic       tx_busy,
    output logic       tx_done
);

    if ((CLKS_PER_BIT < 1) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be in 1..65535");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic PARITY_INV = (PARITY_ODD != 0);

    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_e;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        tx_data_out_q, tx_data_out_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;
    logic        bit_end_s;

    assign bit_end_s = (baud_cnt_q == BAUD_LAST);

    // Next-state, baud counter, bit index and shift register update.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_cnt_d = 16'd0;
                bit_idx_d  = 3'd0;
                if (tx_start) begin
                    shift_d  = tx_data_in;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_of(tx_data_in, PARITY_INV);
`endif
                    state_d  = START;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = 16'd0;
                bit_idx_d  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the line changes on the same edge as the state.
    always_comb begin
        tx_data_out_d = 1'b1;
        case (state_d)
            IDLE:    tx_data_out_d = 1'b1;
            START:   tx_data_out_d = 1'b0;
            DATA:    tx_data_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_data_out_d = parity_d;
`endif
            STOP:    tx_data_out_d = 1'b1;
            default: tx_data_out_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
        tx_done_d = (state_q == STOP) && (state_d == IDLE);
    end

    // State and datapath registers; reset drives the line idle-high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            baud_cnt_q    <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
            tx_data_out_q <= 1'b1;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
            tx_data_out_q <= tx_data_out_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
        end
    end

    assign tx_data_out = tx_data_out_q;
    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's `uart_rx` path. It accepts an 8-bit byte on a single-cycle start strobe and shifts out one frame, LSB first: start bit (0), 8 data bits, an optional even/odd parity bit, and a stop bit (1). Each bit is held for a parameterised number of clock cycles. It sits between the host-side byte source and the serial line feeding the receiver.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..65535.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity (used only when parity is compiled in).

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  one-cycle request to send `tx_data_in`.
- `tx_data_in`  in  8  byte to transmit; sampled only on the accepting edge.
- `tx_data_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is in flight.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: the line is 1. If `tx_start`=1 at a clock edge:
  - load `tx_data_in` into the shift register;
  - compute the parity bit, which is the XOR of the data, inverted when `PARITY_ODD`=1;
  - go to START.
- START: the line is 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: the line carries `shift[0]`.
  - After `CLKS_PER_BIT` cycles, shift right and increment the bit index.
  - After bit 7, go to PARITY (or to STOP if parity is compiled out).
- PARITY: the line carries the parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: the line is 1 for `CLKS_PER_BIT` cycles, then go to IDLE with `tx_done`=1 for that one cycle.
- Baud counter: 16-bit, counts 0..`CLKS_PER_BIT`-1, and clears on every bit transition and in IDLE.
- Bit index: 3-bit, counts 0..7.
- `tx_start` while `tx_busy`=1 is ignored. No queueing and no error flag.
- `tx_data_in` changes after acceptance do not affect the frame in flight.

## Timing
- Reset values:
  - `tx_data_out`=1, `tx_busy`=0, `tx_done`=0;
  - state is IDLE, counters are 0, shift register is 0.
- Reset mid-frame: the line returns to 1 immediately (asynchronously) and the frame is abandoned. No `tx_done` is produced.
- All outputs are registered.
- Acceptance edge E: from E, `tx_busy`=1 and `tx_data_out`=0 (start bit).
- Frame length from E:
  - 11×`CLKS_PER_BIT` cycles with parity;
  - 10×`CLKS_PER_BIT` cycles without parity.
- At the end of the frame:
  - `tx_busy` falls and `tx_done` rises on the same edge;
  - the state is IDLE and the line is 1.
- Back-to-back frames: a `tx_start` sampled in the `tx_done` cycle is accepted.
  - The next start bit begins on the following edge.
  - Minimum inter-frame idle is therefore exactly 1 cycle of line=1 after the stop bit.
- `CLKS_PER_BIT`=1: each bit lasts exactly 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and the frame is 11 bits (start, 8 data, parity, stop).
- `UART_TX_PARITY_EN` undefined:
  - the PARITY state, parity register and `PARITY_ODD` logic are removed;
  - DATA goes directly to STOP and the frame is 10 bits.

## Test plan
- Reset check: hold `reset`=0, then release → `tx_data_out`=1, `tx_busy`=0, `tx_done`=0. Pulse `reset` low mid-DATA → line is 1 at once, state is IDLE, no `tx_done`.
- `CLKS_PER_BIT`=4, parity enabled, even, send 0xA5 → line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles. `tx_busy` high for 44 cycles, then a single-cycle `tx_done`.
- `PARITY_ODD`=1, send 0x07 (three ones) → parity bit 0. With even parity, the same byte → parity bit 1.
- `tx_start` pulsed with 0xFF during the DATA state of a 0x3C frame → ignored. The 0x3C frame is intact and no second frame follows.
- Back-to-back, `CLKS_PER_BIT`=1: send 0x55, then assert `tx_start` with 0x0F in the `tx_done` cycle. Expect exactly 1 idle-high cycle between the stop bit and the second start bit, and the second frame correct.
- Build without `UART_TX_PARITY_EN`, `CLKS_PER_BIT`=2, send 0x81 → line sequence 0,1,0,0,0,0,0,0,1,1, each bit held 2 cycles, frame length 20 cycles.
